// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM slot arbiter.
//   arb_st_t : arbiter FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   slot_w() : width of a slot index for a given slot count
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_st_t;

    function automatic int slot_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational grant picker for the SDRAM slot arbiter.
// Priority slots (prio_i) win first, lowest index first. Otherwise the first
// pending slot strictly after ptr_i wins, wrapping around.
//   pend_i : per-slot pending request
//   prio_i : per-slot high-priority mask
//   ptr_i  : round-robin pointer (last non-priority grant)
//   gnt_o  : granted slot index (valid when any_o)
//   any_o  : at least one slot pending
module jtframe_rr_pick
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int SW    = slot_w(SLOTS)
)(
    input  logic [SLOTS-1:0] pend_i,
    input  logic [SLOTS-1:0] prio_i,
    input  logic [SW-1:0]    ptr_i,
    output logic [SW-1:0]    gnt_o,
    output logic             any_o
);

    logic          found;
    logic [SW:0]   idx;

    assign any_o = |pend_i;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && pend_i[i] && prio_i[i]) begin
                gnt_o = SW'(i);
                found = 1'b1;
            end
        end
        // One extra bit so ptr + k never overflows before the wrap subtract.
        for (int k = 1; k <= SLOTS; k++) begin
            idx = {1'b0, ptr_i} + (SW+1)'(k);
            if (idx >= (SW+1)'(SLOTS))
                idx = idx - (SW+1)'(SLOTS);
            if (!found && pend_i[idx[SW-1:0]]) begin
                gnt_o = idx[SW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_slot_arb.sv
// Arbitrates per-slot SDRAM reads onto a single controller port. Each slot owns
// a one-entry cache (tag + data); slot_ok_o is raised while the slot's current
// address hits its cache. Misses are served one at a time via round-robin with
// an optional high-priority slot mask.
// Optional build macro: JTFRAME_SDRAM_STATS_EN enables saturating idle/busy
// cycle counters; without it idle_cnt_o/busy_cnt_o are constant zero.
// Ports:
//   rst_i, clk_i        async active-high reset, clock
//   slot_cs_i/clr_i     per-slot request / cache invalidate
//   slot_addr_i         per-slot address, slot n at [n*AW+:AW]
//   slot_ok_o/dout_o    per-slot hit flag / cached data
//   sdram_req_o/addr_o  controller request and address
//   sdram_ack_i         controller accepted the request
//   data_rdy_i/read_i   read data strobe and data
//   refresh_en_o        arbiter idle with nothing pending
//   idle_cnt_o/busy_cnt_o statistics counters
module jtframe_sdram_slot_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int               SLOTS     = 4,
    parameter int               AW        = 22,
    parameter int               DW        = 32,
    parameter logic [SLOTS-1:0] PRIO_MASK = '0
)(
    input  logic                rst_i,
    input  logic                clk_i,
    input  logic [SLOTS-1:0]    slot_cs_i,
    input  logic [SLOTS-1:0]    slot_clr_i,
    input  logic [SLOTS*AW-1:0] slot_addr_i,
    output logic [SLOTS-1:0]    slot_ok_o,
    output logic [SLOTS*DW-1:0] slot_dout_o,
    output logic                sdram_req_o,
    output logic [AW-1:0]       sdram_addr_o,
    input  logic                sdram_ack_i,
    input  logic                data_rdy_i,
    input  logic [DW-1:0]       data_read_i,
    output logic                refresh_en_o,
    output logic [31:0]         idle_cnt_o,
    output logic [31:0]         busy_cnt_o
);

    localparam int SW = slot_w(SLOTS);

    logic [SLOTS-1:0][AW-1:0] addr_a;
    logic [SLOTS-1:0][AW-1:0] tag_q;
    logic [SLOTS-1:0][DW-1:0] dout_q;
    logic [SLOTS-1:0]         valid_q, valid_d;
    logic [SLOTS-1:0]         hit, pend;
    arb_st_t                  st_q, st_d;
    logic [SW-1:0]            gnt_q, ptr_q, pick_gnt;
    logic                     pick_any;
    logic [AW-1:0]            req_addr_q;
    logic                     issue, fill;

    assign addr_a = slot_addr_i;

    always_comb begin
        hit = '0;
        for (int n = 0; n < SLOTS; n++)
            hit[n] = valid_q[n] && (tag_q[n] == addr_a[n]);
    end

    assign pend        = slot_cs_i & ~hit;
    assign slot_ok_o   = slot_cs_i & hit;
    assign slot_dout_o = dout_q;

    jtframe_rr_pick #(.SLOTS(SLOTS), .SW(SW)) u_pick (
        .pend_i (pend),
        .prio_i (PRIO_MASK),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .any_o  (pick_any)
    );

    assign issue = (st_q == IDLE) && pick_any;
    assign fill  = (st_q == WAIT) && data_rdy_i;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) st_q <= IDLE;
        else       st_q <= st_d;
    end

    // FSM: next state. data_rdy in REQ and ack/data_rdy in IDLE are ignored.
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (pick_any)    st_d = REQ;
            REQ:     if (sdram_ack_i) st_d = WAIT;
            WAIT:    if (data_rdy_i)  st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sdram_req_o  = (st_q == REQ);
        refresh_en_o = (st_q == IDLE) && !pick_any;
    end

    assign sdram_addr_o = req_addr_q;

    // A clear or cs drop beats a fill landing on the same edge.
    always_comb begin
        valid_d = valid_q;
        if (fill) valid_d[gnt_q] = 1'b1;
        valid_d = valid_d & slot_cs_i & ~slot_clr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q      <= '0;
            ptr_q      <= SW'(SLOTS-1);
            req_addr_q <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            dout_q     <= '0;
        end else begin
            valid_q <= valid_d;
            if (issue) begin
                gnt_q      <= pick_gnt;
                req_addr_q <= addr_a[pick_gnt];
                // Priority grants leave the round-robin order untouched.
                if (!PRIO_MASK[pick_gnt]) ptr_q <= pick_gnt;
            end
            // Fill uses the latched address, so a mid-flight address change
            // shows up as a tag miss and triggers a fresh request.
            if (fill) begin
                tag_q[gnt_q]  <= req_addr_q;
                dout_q[gnt_q] <= data_read_i;
            end
        end
    end

`ifdef JTFRAME_SDRAM_STATS_EN
    logic [31:0] idle_q, busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
            busy_q <= '0;
        end else begin
            if (refresh_en_o && (idle_q != 32'hFFFF_FFFF)) idle_q <= idle_q + 32'd1;
            if ((st_q != IDLE) && (busy_q != 32'hFFFF_FFFF)) busy_q <= busy_q + 32'd1;
        end
    end

    assign idle_cnt_o = idle_q;
    assign busy_cnt_o = busy_q;
`else
    assign idle_cnt_o = '0;
    assign busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_jtframe_sdram_slot_arb.sv
module tb_jtframe_sdram_slot_arb;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       cs, clr;
    logic [3:0][21:0] addr;
    logic             ack, rdy;
    logic [31:0]      data;

    logic [3:0]       ok_n, ok_p;
    logic [3:0][31:0] dout_n, dout_p;
    logic             req_n, req_p, ref_n, ref_p;
    logic [21:0]      saddr_n, saddr_p;
    logic [31:0]      idle_n, busy_n, idle_p, busy_p;

    int checks = 0;
    int errors = 0;
    int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
    logic [21:0] a;
    logic [1:0]  s;
    int          nreq;

    always #5 clk = ~clk;

    jtframe_sdram_slot_arb #(.SLOTS(4), .AW(22), .DW(32), .PRIO_MASK(4'b0000)) dut (
        .rst_i(rst), .clk_i(clk), .slot_cs_i(cs), .slot_clr_i(clr), .slot_addr_i(addr),
        .slot_ok_o(ok_n), .slot_dout_o(dout_n), .sdram_req_o(req_n), .sdram_addr_o(saddr_n),
        .sdram_ack_i(ack), .data_rdy_i(rdy), .data_read_i(data), .refresh_en_o(ref_n),
        .idle_cnt_o(idle_n), .busy_cnt_o(busy_n)
    );

    jtframe_sdram_slot_arb #(.SLOTS(4), .AW(22), .DW(32), .PRIO_MASK(4'b1000)) dut_p (
        .rst_i(rst), .clk_i(clk), .slot_cs_i(cs), .slot_clr_i(clr), .slot_addr_i(addr),
        .slot_ok_o(ok_p), .slot_dout_o(dout_p), .sdram_req_o(req_p), .sdram_addr_o(saddr_p),
        .sdram_ack_i(ack), .data_rdy_i(rdy), .data_read_i(data), .refresh_en_o(ref_p),
        .idle_cnt_o(idle_p), .busy_cnt_o(busy_p)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cs = '0; clr = '0; ack = 1'b0; rdy = 1'b0; data = '0; addr = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input bit sel, output logic [21:0] ra);
        int n = 0;
        while (((sel ? req_p : req_n) == 1'b0) && n < 40) begin
            tick();
            n++;
        end
        chk("req_seen", sel ? req_p : req_n, 1'b1);
        ra = sel ? saddr_p : saddr_n;
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] d);
        repeat (3) tick();
        data = d; rdy = 1'b1; tick(); rdy = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_req", req_n, 1'b0);
        chk("rst_addr", saddr_n, 22'h0);
        chk("rst_dout_lo", {dout_n[1], dout_n[0]}, 64'h0);
        chk("rst_dout_hi", {dout_n[3], dout_n[2]}, 64'h0);
        chk("rst_ok", ok_n, 4'b0000);
        chk("rst_refresh", ref_n, 1'b1);
        chk("rst_idle_cnt", idle_n, 32'd0);

        // T1 single slot
        addr[2] = 22'h0A_8000; cs = 4'b0100;
        wait_req(0, a);
        chk("t1_addr", a, 22'h0A_8000);
        do_ack();
        chk("t1_ok_wait", ok_n[2], 1'b0);
        chk("t1_refresh_busy", ref_n, 1'b0);
        do_fill(32'hDEAD_BEEF);
        chk("t1_ok", ok_n[2], 1'b1);
        chk("t1_dout", dout_n[2], 32'hDEAD_BEEF);
        nreq = 0;
        repeat (8) begin tick(); if (req_n) nreq++; end
        chk("t1_no_second_req", nreq, 0);
        chk("t1_refresh_idle", ref_n, 1'b1);

        // T2 round robin, slots 0,1,3
        do_reset();
        addr[0] = 22'h00_0001; addr[1] = 22'h10_0001; addr[3] = 22'h30_0001;
        cs = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_req(0, a);
            s = a[21:20];
            chk("t2_rr_order", s, exp_rr[i]);
            do_ack();
            do_fill(32'h1000 + i);
            addr[s] = addr[s] + 22'd1;
        end

        // T3 priority slot 3 on the masked instance
        do_reset();
        addr[0] = 22'h00_0010; addr[1] = 22'h10_0010; addr[3] = 22'h30_0010;
        cs = 4'b0011;
        wait_req(1, a);
        chk("t3_first_rr", a[21:20], 2'd0);
        do_ack(); do_fill(32'h3000_0000);
        addr[0] = addr[0] + 22'd1; cs = 4'b1011;
        wait_req(1, a);
        chk("t3_prio_a", a[21:20], 2'd3);
        do_ack(); do_fill(32'h3000_0001);
        addr[3] = addr[3] + 22'd1;
        wait_req(1, a);
        chk("t3_prio_b", a[21:20], 2'd3);
        do_ack(); do_fill(32'h3000_0002);
        cs = 4'b0011;
        wait_req(1, a);
        chk("t3_ptr_kept", a[21:20], 2'd1);
        do_ack(); do_fill(32'h3000_0003);

        // T4 address change while waiting for data
        do_reset();
        addr[1] = 22'h10_0100; cs = 4'b0010;
        wait_req(0, a);
        chk("t4_addr_a", a, 22'h10_0100);
        do_ack();
        addr[1] = 22'h10_0200;
        do_fill(32'hCAFE_0001);
        chk("t4_ok_stale", ok_n[1], 1'b0);
        chk("t4_dout_stale", dout_n[1], 32'hCAFE_0001);
        wait_req(0, a);
        chk("t4_addr_b", a, 22'h10_0200);
        do_ack(); do_fill(32'hCAFE_0002);
        chk("t4_ok_new", ok_n[1], 1'b1);
        chk("t4_dout_new", dout_n[1], 32'hCAFE_0002);

        // T5 clear in fill cycle, then reset during REQ
        do_reset();
        addr[1] = 22'h10_0700; cs = 4'b0010;
        wait_req(0, a);
        do_ack(); do_fill(32'h1111_1111);
        chk("t5_ok1", ok_n, 4'b0010);
        addr[0] = 22'h00_0500; cs = 4'b0011;
        wait_req(0, a);
        chk("t5_addr0", a, 22'h00_0500);
        do_ack();
        repeat (3) tick();
        data = 32'h2222_2222; rdy = 1'b1; clr = 4'b0001;
        tick();
        rdy = 1'b0; clr = 4'b0000;
        chk("t5_clr_wins", ok_n, 4'b0010);
        wait_req(0, a);
        chk("t5_rereq", a, 22'h00_0500);
        rst = 1'b1;
        #1;
        chk("t5_rst_req", req_n, 1'b0);
        chk("t5_rst_ok", ok_n, 4'b0000);
        tick();
        cs = 4'b0000; rst = 1'b0;
        ack = 1'b1; rdy = 1'b1; data = 32'hBAD0_BAD0;
        tick();
        ack = 1'b0; rdy = 1'b0;
        chk("t5_late_req", req_n, 1'b0);
        chk("t5_late_dout", dout_n[0], 32'h0);
        chk("t5_late_refresh", ref_n, 1'b1);

        // T6 idle statistics
        do_reset();
        repeat (100) tick();
`ifdef JTFRAME_SDRAM_STATS_EN
        chk("t6_idle_cnt", idle_n, 32'd100);
`else
        chk("t6_idle_cnt", idle_n, 32'd0);
`endif
        chk("t6_busy_cnt", busy_n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
